// File: rtl/rubiks_polibot_seq_uc_if.sv
// Handshake bundle between the solve sequencer and the camera, classifier,
// serial-link and actuator datapaths plus the start/debug I/O.
interface rubiks_polibot_seq_uc_if #(
  parameter int N_FACES = 6,
  parameter int MOVE_W  = 7
);
  localparam int FACE_W = (N_FACES > 1) ? $clog2(N_FACES) : 1;

  logic              iniciar;
  logic              parar;
  logic              imagem_recebida;
  logic              cores_identificadas;
  logic              cores_transmitidas;
  logic              fim_movimento;
  logic              movimentos_recebidos;
  logic [MOVE_W-1:0] num_movimentos;

  logic              captura_imagem;
  logic              identificar_cores;
  logic              enviar_cores;
  logic              aciona_movimento;
  logic              receber_movimentos;
  logic              modo_face;
  logic [FACE_W-1:0] face_idx;
  logic [MOVE_W-1:0] movimento_idx;
  logic              pronto;
  logic              erro;
  logic [3:0]        erro_codigo;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, parar, imagem_recebida, cores_identificadas, cores_transmitidas,
           fim_movimento, movimentos_recebidos, num_movimentos,
    input  captura_imagem, identificar_cores, enviar_cores, aciona_movimento,
           receber_movimentos, modo_face, face_idx, movimento_idx, pronto, erro,
           erro_codigo, db_estado
  );

  modport slave (
    input  iniciar, parar, imagem_recebida, cores_identificadas, cores_transmitidas,
           fim_movimento, movimentos_recebidos, num_movimentos,
    output captura_imagem, identificar_cores, enviar_cores, aciona_movimento,
           receber_movimentos, modo_face, face_idx, movimento_idx, pronto, erro,
           erro_codigo, db_estado
  );
endinterface

// File: rtl/rubiks_polibot_seq_uc.sv
// Solve sequencer: scans N_FACES faces, then receives and executes a move list.
// Wait states are guarded by a watchdog; image capture may be retried.
module rubiks_polibot_seq_uc #(
  parameter int N_FACES        = 6,
  parameter int STEPS_PER_FACE = 2,
  parameter int MOVE_W         = 7,
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 12000000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  rubiks_polibot_seq_uc_if.slave bus
);
  localparam int FACE_W  = (N_FACES > 1) ? $clog2(N_FACES) : 1;
  localparam int STEP_W  = (STEPS_PER_FACE > 1) ? $clog2(STEPS_PER_FACE) : 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [FACE_W-1:0]    LAST_FACE = FACE_W'(N_FACES - 1);
  localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(STEPS_PER_FACE - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_INICIAL              = 4'h0,
    S_PREPARA              = 4'h1,
    S_RECEBE_IMAGEM        = 4'h2,
    S_IDENTIFICA_CORES     = 4'h3,
    S_TRANSMITE_CORES      = 4'h4,
    S_MUDA_FACE            = 4'h5,
    S_ATUALIZA_PASSO       = 4'h6,
    S_ATUALIZA_FACE        = 4'h7,
    S_RECEBE_MOVIMENTOS    = 4'h8,
    S_PREPARA_MOVIMENTOS   = 4'h9,
    S_MOVIMENTA            = 4'hA,
    S_ATUALIZA_MOVIMENTO   = 4'hB,
    S_FIM                  = 4'hC,
    S_ERRO                 = 4'hD
  } state_t;

  state_t                 state_q, state_d;
  logic [FACE_W-1:0]      face_q, face_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [MOVE_W-1:0]      mov_q, mov_d;
  logic [MOVE_W-1:0]      cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  logic [3:0]             cod_q, cod_d;
  logic                   gap_q, gap_d;
  logic                   timeout;
  logic                   is_wait;

  assign timeout = (wd_q == WD_LAST);
  assign is_wait = state_q inside {S_RECEBE_IMAGEM, S_IDENTIFICA_CORES, S_TRANSMITE_CORES,
                                   S_MUDA_FACE, S_RECEBE_MOVIMENTOS, S_MOVIMENTA};

  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    step_d  = step_q;
    retry_d = retry_q;
    mov_d   = mov_q;
    cnt_d   = cnt_q;
    cod_d   = cod_q;
    gap_d   = 1'b0;
    wd_d    = '0;
    if (bus.parar && state_q != S_INICIAL) begin
      state_d = S_INICIAL;
      face_d  = '0;
      step_d  = '0;
      retry_d = '0;
      mov_d   = '0;
      cnt_d   = '0;
      cod_d   = '0;
    end else begin
      // Completion is tested before timeout so a same-cycle completion wins.
      case (state_q)
        S_INICIAL: if (bus.iniciar) state_d = S_PREPARA;
        S_PREPARA: begin
          face_d  = '0;
          step_d  = '0;
          retry_d = '0;
          mov_d   = '0;
          cnt_d   = '0;
          state_d = S_RECEBE_IMAGEM;
        end
        S_RECEBE_IMAGEM:
          if (bus.imagem_recebida) state_d = S_IDENTIFICA_CORES;
          else if (timeout) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_W'(1);
              gap_d   = 1'b1;
            end else state_d = S_ERRO;
          end
        S_IDENTIFICA_CORES:
          if (bus.cores_identificadas) state_d = S_TRANSMITE_CORES;
          else if (timeout) state_d = S_ERRO;
        S_TRANSMITE_CORES:
          if (bus.cores_transmitidas)
            state_d = (face_q == LAST_FACE) ? S_RECEBE_MOVIMENTOS : S_MUDA_FACE;
          else if (timeout) state_d = S_ERRO;
        S_MUDA_FACE:
          if (bus.fim_movimento) state_d = S_ATUALIZA_PASSO;
          else if (timeout) state_d = S_ERRO;
        S_ATUALIZA_PASSO:
          if (step_q == LAST_STEP) begin
            step_d  = '0;
            state_d = S_ATUALIZA_FACE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = S_MUDA_FACE;
          end
        S_ATUALIZA_FACE: begin
          face_d  = face_q + FACE_W'(1);
          retry_d = '0;
          state_d = S_RECEBE_IMAGEM;
        end
        S_RECEBE_MOVIMENTOS:
          if (bus.movimentos_recebidos) begin
            cnt_d   = bus.num_movimentos;
            state_d = S_PREPARA_MOVIMENTOS;
          end else if (timeout) state_d = S_ERRO;
        S_PREPARA_MOVIMENTOS: begin
          mov_d   = '0;
          state_d = (cnt_q == '0) ? S_FIM : S_MOVIMENTA;
        end
        S_MOVIMENTA:
          if (bus.fim_movimento) state_d = S_ATUALIZA_MOVIMENTO;
          else if (timeout) state_d = S_ERRO;
        S_ATUALIZA_MOVIMENTO:
          if (mov_q == cnt_q - MOVE_W'(1)) state_d = S_FIM;
          else begin
            mov_d   = mov_q + MOVE_W'(1);
            state_d = S_MOVIMENTA;
          end
        S_FIM: if (bus.iniciar) state_d = S_PREPARA;
        S_ERRO:
          if (bus.iniciar) begin
            state_d = S_INICIAL;
            cod_d   = '0;
          end
        default: state_d = S_INICIAL;
      endcase
      if (state_d == S_ERRO && state_q != S_ERRO) cod_d = state_q;
    end
    // Any state change or capture retry restarts the watchdog.
    if (state_d == state_q && !gap_d && is_wait) wd_d = wd_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INICIAL;
      face_q  <= '0;
      step_q  <= '0;
      retry_q <= '0;
      mov_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      cod_q   <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      face_q  <= face_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      mov_q   <= mov_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      cod_q   <= cod_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    bus.captura_imagem     = (state_q == S_RECEBE_IMAGEM) && !gap_q;
    bus.identificar_cores  = (state_q == S_IDENTIFICA_CORES);
    bus.enviar_cores       = (state_q == S_TRANSMITE_CORES);
    bus.aciona_movimento   = (state_q == S_MUDA_FACE) || (state_q == S_MOVIMENTA);
    bus.modo_face          = (state_q == S_MUDA_FACE);
    bus.receber_movimentos = (state_q == S_RECEBE_MOVIMENTOS);
    bus.pronto             = (state_q == S_FIM);
    bus.erro               = (state_q == S_ERRO);
    bus.db_estado          = (state_q > S_ERRO) ? 4'hF : 4'(state_q);
  end

  assign bus.face_idx      = face_q;
  assign bus.movimento_idx = mov_q;
  assign bus.erro_codigo   = cod_q;
endmodule
